// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ready
// handshake to instruction memory and drives the IF/ID write/flush controls.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        IFIDWrite_o,
    output logic        IFFlush_o
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Outputs are combinational so IF/ID captures them on the same edge as the PC update.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = 32'd0;
        pc4_o       = 32'd0;
        instr_o     = 32'd0;
        IFIDWrite_o = 1'b0;
        IFFlush_o   = 1'b0;
        if (rst_i) begin
            case (state)
                FETCH: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc;
                    if (branch_taken_i) begin
                        IFFlush_o = 1'b1;
                    end else if (imem_ready_i && !stall_i) begin
                        IFIDWrite_o = 1'b1;
                        pc4_o       = pc_plus4;
                        instr_o     = imem_rdata_i;
                    end else if (!imem_ready_i && !stall_i) begin
                        IFFlush_o = 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken_i) begin
                        IFFlush_o = 1'b1;
                    end else if (!stall_i) begin
                        IFIDWrite_o = 1'b1;
                        pc4_o       = pc_plus4;
                        instr_o     = hold_instr;
                    end
                end
                DRAIN: begin
                    // Old address stays on the bus until the abandoned fetch completes.
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc;
                    IFFlush_o   = !stall_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= BUBBLE_INSTR;
            redirect_pc <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken_i) begin
                        if (imem_ready_i) begin
                            pc <= branch_target_i;
                        end else begin
                            redirect_pc <= branch_target_i;
                            state       <= DRAIN;
                        end
                    end else if (imem_ready_i && !stall_i) begin
                        pc <= pc_plus4;
                    end else if (imem_ready_i && stall_i) begin
                        hold_instr <= imem_rdata_i;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken_i) begin
                        pc         <= branch_target_i;
                        hold_instr <= BUBBLE_INSTR;
                        state      <= FETCH;
                    end else if (!stall_i) begin
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // A newer branch during the drain replaces the pending target.
                    if (branch_taken_i) begin
                        redirect_pc <= branch_target_i;
                    end
                    if (imem_ready_i) begin
                        pc    <= branch_taken_i ? branch_target_i : redirect_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit; each row is one clock cycle
// of stimulus with the outputs expected during that cycle.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc4_o;
    logic [31:0] instr_o;
    logic        IFIDWrite_o;
    logic        IFFlush_o;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.RESET_PC(32'h0), .BUBBLE_INSTR(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i),
        .pc4_o(pc4_o), .instr_o(instr_o),
        .IFIDWrite_o(IFIDWrite_o), .IFFlush_o(IFFlush_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_0013;
    endfunction

    typedef struct {
        logic        rdy, stall, br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        wr, fl;
        logic [31:0] pc4, instr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rdy, stall, br, input logic [31:0] tgt,
                       input logic req, input logic [31:0] addr,
                       input logic wr, fl, input logic [31:0] pc4, instr);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.wr = wr; v.fl = fl; v.pc4 = pc4; v.instr = instr;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [98:0] exp);
        logic [98:0] act;
        act = {imem_req_o, imem_addr_o, IFIDWrite_o, IFFlush_o, pc4_o, instr_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h wr=%b fl=%b pc4=%h instr=%h, want req=%b addr=%h wr=%b fl=%b pc4=%h instr=%h",
                     name, act[98], act[97:66], act[65], act[64], act[63:32], act[31:0],
                     exp[98], exp[97:66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic rdy, stall, br, input logic [31:0] tgt, input logic [31:0] rdata);
        imem_ready_i    = rdy;
        stall_i         = stall;
        branch_taken_i  = br;
        branch_target_i = tgt;
        imem_rdata_i    = rdata;
    endtask

    initial begin
        // rdy stall br tgt | req addr wr fl pc4 instr
        add(1,0,0,0,           1,32'h0,1,0,32'h4,mem(32'h0));
        add(1,0,0,0,           1,32'h4,1,0,32'h8,mem(32'h4));
        add(1,0,0,0,           1,32'h8,1,0,32'hC,mem(32'h8));
        add(0,0,0,0,           1,32'hC,0,1,0,0);
        add(0,0,0,0,           1,32'hC,0,1,0,0);
        add(1,0,0,0,           1,32'hC,1,0,32'h10,mem(32'hC));
        add(1,1,0,0,           1,32'h10,0,0,0,0);
        add(0,1,0,0,           0,32'h0,0,0,0,0);
        add(0,1,0,0,           0,32'h0,0,0,0,0);
        add(0,0,0,0,           0,32'h0,1,0,32'h14,mem(32'h10));
        add(1,0,0,0,           1,32'h14,1,0,32'h18,mem(32'h14));
        add(0,0,1,32'h40,      1,32'h18,0,1,0,0);
        add(0,0,0,0,           1,32'h18,0,1,0,0);
        add(0,0,1,32'h80,      1,32'h18,0,1,0,0);
        add(1,0,0,0,           1,32'h18,0,1,0,0);
        add(1,0,0,0,           1,32'h80,1,0,32'h84,mem(32'h80));
        add(1,1,1,32'h40,      1,32'h84,0,1,0,0);
        add(1,0,0,0,           1,32'h40,1,0,32'h44,mem(32'h40));
        add(0,0,1,32'h100,     1,32'h44,0,1,0,0);
        add(1,1,0,0,           1,32'h44,0,0,0,0);
        add(1,0,0,0,           1,32'h100,1,0,32'h104,mem(32'h100));
        add(1,1,0,0,           1,32'h104,0,0,0,0);
        add(0,1,1,32'h200,     0,32'h0,0,1,0,0);
        add(1,0,0,0,           1,32'h200,1,0,32'h204,mem(32'h200));
        add(1,0,1,32'hFFFF_FFFC,1,32'h204,0,1,0,0);
        add(1,0,0,0,           1,32'hFFFF_FFFC,1,0,32'h0,mem(32'hFFFF_FFFC));
        add(1,0,0,0,           1,32'h0,1,0,32'h4,mem(32'h0));
        add(0,1,0,0,           1,32'h4,0,0,0,0);
        add(1,0,0,0,           1,32'h4,1,0,32'h8,mem(32'h4));

        rst_i = 1'b0;
        drive(1, 0, 0, 0, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk_i);
        #1 check("reset_outputs_zero", '0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].rdy, tv[i].stall, tv[i].br, tv[i].tgt,
                  tv[i].rdy ? mem(tv[i].addr) : 32'hDEAD_BEEF);
            #1 check($sformatf("vec%0d", i),
                     {tv[i].req, tv[i].addr, tv[i].wr, tv[i].fl, tv[i].pc4, tv[i].instr});
            @(negedge clk_i);
        end

        // Reset asserted while draining: outputs drop at once, restart from RESET_PC.
        drive(0, 0, 1, 32'h300, 32'hDEAD_BEEF);
        #1 check("enter_drain", {1'b1, 32'h8, 1'b0, 1'b1, 64'h0});
        @(negedge clk_i);
        drive(0, 0, 0, 0, 32'hDEAD_BEEF);
        #1 check("in_drain", {1'b1, 32'h8, 1'b0, 1'b1, 64'h0});
        #1 rst_i = 1'b0;
        drive(1, 0, 1, 32'h300, mem(32'h8));
        #1 check("reset_mid_drain", '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1, 0, 0, 0, mem(32'h0));
        #1 check("restart_after_reset", {1'b1, 32'h0, 1'b1, 1'b0, 32'h4, mem(32'h0)});
        @(negedge clk_i);
        drive(1, 0, 0, 0, mem(32'h4));
        #1 check("restart_next", {1'b1, 32'h4, 1'b1, 1'b0, 32'h8, mem(32'h4)});
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the writer side of the IF/ID pipeline register.
- Holds the PC and runs a request/ready handshake to instruction memory (variable latency, 1 outstanding request).
- Produces pc4/instr plus the IF/ID write-enable and flush controls, honouring hazard stalls and branch redirects from ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUBBLE_INSTR, 32'h0000_0000, instruction word meaning NOP; also the value IF/ID takes on flush.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
imem_req_o  output  1  fetch request valid.
imem_addr_o  output  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
imem_ready_i  input  1  memory returns imem_rdata_i for the current request this cycle.
imem_rdata_i  input  32  fetched instruction; valid only when imem_ready_i=1.
stall_i  input  1  hazard unit: IF/ID must hold, PC must not advance.
branch_taken_i  input  1  ID resolved a taken branch/jump this cycle.
branch_target_i  input  32  redirect PC, sampled when branch_taken_i=1.
pc4_o  output  32  value to load into IF/ID pc4.
instr_o  output  32  value to load into IF/ID instr.
IFIDWrite_o  output  1  IF/ID write enable.
IFFlush_o  output  1  IF/ID flush (load bubble).

Behaviour:
- Registered state: pc, state {FETCH, HOLD, DRAIN}, hold_instr (32b), redirect_pc (32b). Outputs are combinational from state and inputs, so IF/ID captures them on the same edge.
- Reset (rst_i=0, asynchronous): pc=RESET_PC, state=FETCH, hold_instr=BUBBLE_INSTR.
  - While reset is asserted all outputs are 0, including imem_req_o.
  - First request issues in the first cycle after release.
- pc4 = pc + 4, modulo 2^32. pc 32'hFFFF_FFFC wraps to 0.
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - branch_taken_i=1 (highest priority): IFFlush_o=1, IFIDWrite_o=0.
    - If imem_ready_i=1: pc<=branch_target_i, stay FETCH, returned data dropped.
    - Else: redirect_pc<=branch_target_i, go DRAIN.
  - Else if imem_ready_i=1 and stall_i=0: IFIDWrite_o=1, pc4_o=pc+4, instr_o=imem_rdata_i, pc<=pc+4.
  - Else if imem_ready_i=1 and stall_i=1: IFIDWrite_o=0, hold_instr<=imem_rdata_i, go HOLD.
  - Else if imem_ready_i=0 and stall_i=0: IFFlush_o=1 (bubble into IF/ID), pc unchanged.
  - Else (not ready, stalled): IFIDWrite_o=0, IFFlush_o=0.
- HOLD: imem_req_o=0.
  - branch_taken_i=1: IFFlush_o=1, pc<=branch_target_i, buffer discarded, go FETCH.
  - Else if stall_i=0: IFIDWrite_o=1, pc4_o=pc+4, instr_o=hold_instr, pc<=pc+4, go FETCH.
  - Else all controls 0, stay HOLD.
- DRAIN: imem_req_o=1, imem_addr_o=pc (old address kept until the handshake completes). IFFlush_o=1 when stall_i=0, else 0. IFIDWrite_o=0.
  - branch_taken_i=1: redirect_pc<=branch_target_i (latest target wins).
  - imem_ready_i=1: data dropped; pc<=(branch_taken_i ? branch_target_i : redirect_pc); go FETCH.
- IFIDWrite_o and IFFlush_o are never both 1.
- pc4_o/instr_o are 0 whenever IFIDWrite_o=0.
- A flush overrides stall_i (branch priority).
- Reset mid-request: request abandoned, memory side must tolerate the dropped handshake; restart at RESET_PC.

Test Plan:
- Reset, RESET_PC=0, ready always 1, no stall → IFIDWrite_o=1 every cycle; (pc4,instr) = (4,mem[0]), (8,mem[4]), (12,mem[8]); imem_addr_o 0,4,8.
- Ready delayed 2 cycles per request → imem_addr_o stable for 3 cycles; IFFlush_o=1 on the 2 waiting cycles, IFIDWrite_o=1 on the third with instr=mem[addr].
- Ready at pc=8 while stall_i=1 for 3 cycles → state HOLD, imem_req_o=0, controls 0. On release: IFIDWrite_o=1, pc4_o=12, instr_o=mem[8]; next addr 12.
- branch_taken_i=1, target 0x40, while request to 0x10 is pending (ready 2 cycles later) → DRAIN, addr stays 0x10 until ready, data dropped, IFFlush_o=1; next request addr 0x40.
  - Second branch to 0x80 during DRAIN → next addr 0x80.
- branch_taken_i, stall_i and imem_ready_i all 1 in FETCH → IFFlush_o=1, IFIDWrite_o=0, next addr = target.
- pc=32'hFFFF_FFFC, delivered instruction → pc4_o=0, next addr 0.
- rst_i asserted mid-DRAIN → outputs 0 immediately; after release, addr=RESET_PC.
